// File: rtl/bg_loader_buffer.sv
// Writable bias/gate weight buffer: packs a valid/ready element stream into DEPTH rows
// of UNITS_NUM elements and serves whole rows combinationally by address.
module bg_loader_buffer #(
   parameter int D_WL      = 24,
   parameter int UNITS_NUM = 5,
   parameter int DEPTH     = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [D_WL-1:0]           in_data,
   output logic                      busy,
   output logic                      load_done,
   output logic                      loaded,
   input  logic [7:0]                addr,
   output logic [UNITS_NUM*D_WL-1:0] w_o
);

   localparam int ROW_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int UNIT_W   = (UNITS_NUM > 1) ? $clog2(UNITS_NUM) : 1;
   localparam int ROW_BITS = UNITS_NUM * D_WL;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_nx_s;
   logic [ROW_W-1:0]    row_cnt_r;
   logic [ROW_W-1:0]    row_cnt_nx_s;
   logic [UNIT_W-1:0]   unit_cnt_r;
   logic [UNIT_W-1:0]   unit_cnt_nx_s;
   logic                busy_r;
   logic                busy_nx_s;
   logic                in_ready_r;
   logic                in_ready_nx_s;
   logic                load_done_r;
   logic                load_done_nx_s;
   logic                loaded_r;
   logic                loaded_nx_s;
   logic                accept_s;
   logic                last_unit_s;
   logic                last_elem_s;
   logic [ROW_BITS-1:0] rows_r [DEPTH];
   logic [ROW_BITS-1:0] w_s;

   assign accept_s    = in_valid & in_ready_r & (state_r == LOAD);
   assign last_unit_s = (unit_cnt_r == UNIT_W'(UNITS_NUM - 1));
   assign last_elem_s = last_unit_s & (row_cnt_r == ROW_W'(DEPTH - 1));

   // Next-state and next-output logic of the load sequencer.
   always_comb begin
      state_nx_s     = state_r;
      row_cnt_nx_s   = row_cnt_r;
      unit_cnt_nx_s  = unit_cnt_r;
      busy_nx_s      = busy_r;
      in_ready_nx_s  = in_ready_r;
      load_done_nx_s = 1'b0;
      loaded_nx_s    = loaded_r;
      case (state_r)
         IDLE: begin
            if (load_start) begin
               state_nx_s    = LOAD;
               row_cnt_nx_s  = {ROW_W{1'b0}};
               unit_cnt_nx_s = {UNIT_W{1'b0}};
               busy_nx_s     = 1'b1;
               in_ready_nx_s = 1'b1;
               loaded_nx_s   = 1'b0;
            end else begin
               state_nx_s    = IDLE;
               busy_nx_s     = 1'b0;
               in_ready_nx_s = 1'b0;
            end
         end
         LOAD: begin
            if (accept_s) begin
               if (last_elem_s) begin
                  state_nx_s     = IDLE;
                  row_cnt_nx_s   = {ROW_W{1'b0}};
                  unit_cnt_nx_s  = {UNIT_W{1'b0}};
                  busy_nx_s      = 1'b0;
                  in_ready_nx_s  = 1'b0;
                  load_done_nx_s = 1'b1;
                  loaded_nx_s    = 1'b1;
               end else if (last_unit_s) begin
                  unit_cnt_nx_s = {UNIT_W{1'b0}};
                  row_cnt_nx_s  = row_cnt_r + ROW_W'(1);
               end else begin
                  unit_cnt_nx_s = unit_cnt_r + UNIT_W'(1);
               end
            end else begin
               state_nx_s = LOAD;
            end
         end
         default: begin
            state_nx_s    = IDLE;
            row_cnt_nx_s  = {ROW_W{1'b0}};
            unit_cnt_nx_s = {UNIT_W{1'b0}};
            busy_nx_s     = 1'b0;
            in_ready_nx_s = 1'b0;
            loaded_nx_s   = 1'b0;
         end
      endcase
   end

   // Sequencer state, counters and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         row_cnt_r   <= {ROW_W{1'b0}};
         unit_cnt_r  <= {UNIT_W{1'b0}};
         busy_r      <= 1'b0;
         in_ready_r  <= 1'b0;
         load_done_r <= 1'b0;
         loaded_r    <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         row_cnt_r   <= row_cnt_nx_s;
         unit_cnt_r  <= unit_cnt_nx_s;
         busy_r      <= busy_nx_s;
         in_ready_r  <= in_ready_nx_s;
         load_done_r <= load_done_nx_s;
         loaded_r    <= loaded_nx_s;
      end
   end

   // Row storage; the first element of a row lands in the most-significant slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            rows_r[r] <= {ROW_BITS{1'b0}};
         end
      end else if (accept_s) begin
         for (int r = 0; r < DEPTH; r++) begin
            for (int u = 0; u < UNITS_NUM; u++) begin
               if ((row_cnt_r == ROW_W'(r)) && (unit_cnt_r == UNIT_W'(u))) begin
                  rows_r[r][(UNITS_NUM-1-u)*D_WL +: D_WL] <= in_data;
               end
            end
         end
      end else begin
         rows_r <= rows_r;
      end
   end

   // Combinational row read; out-of-range addresses read as zero.
   always_comb begin
      w_s = {ROW_BITS{1'b0}};
      for (int r = 0; r < DEPTH; r++) begin
         if (addr == 8'(r)) begin
            w_s = rows_r[r];
         end else begin
            w_s = w_s;
         end
      end
   end

   assign w_o       = w_s;
   assign busy      = busy_r;
   assign in_ready  = in_ready_r;
   assign load_done = load_done_r;
   assign loaded    = loaded_r;

endmodule

// File: tb/tb_bg_loader_buffer.sv
// Directed self-checking bench for bg_loader_buffer: full loads, stalls, ignored
// restarts, mid-load reset and partial-row reads.
module tb_bg_loader_buffer;

   logic         clk;
   logic         rst;
   logic         load_start;
   logic         in_valid;
   logic         in_ready;
   logic [23:0]  in_data;
   logic         busy;
   logic         load_done;
   logic         loaded;
   logic [7:0]   addr;
   logic [119:0] w_o;

   int checks = 0;
   int errors = 0;
   int accept_cnt = 0;
   int done_cnt = 0;
   int a0;
   int d0;

   bg_loader_buffer #(.D_WL(24), .UNITS_NUM(5), .DEPTH(6)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .busy(busy), .load_done(load_done),
      .loaded(loaded), .addr(addr), .w_o(w_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (in_valid && in_ready) accept_cnt <= accept_cnt + 1;
      if (load_done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [119:0] exp_row(input int r, input logic [23:0] base, input bit konst);
      logic [119:0] v;
      v = 120'h0;
      for (int u = 0; u < 5; u++) begin
         v[(4-u)*24 +: 24] = konst ? base : base + 24'(5*r + u);
      end
      return v;
   endfunction

   // Called at a negedge; leaves the bench at a negedge.
   task automatic start_load();
      load_start = 1'b1;
      @(posedge clk); @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic feed(input int first, input int n, input logic [23:0] base,
                       input bit konst, input bit gap);
      for (int i = first; i < first + n; i++) begin
         in_valid = 1'b1;
         in_data  = konst ? base : base + 24'(i);
         @(posedge clk); @(negedge clk);
         if (gap) begin
            in_valid = 1'b0;
            in_data  = 24'h5A5A5A;
            @(posedge clk); @(negedge clk);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic chk_rows(input string tag, input logic [23:0] base, input bit konst);
      for (int r = 0; r < 6; r++) begin
         addr = 8'(r);
         #1;
         chk($sformatf("%s_row%0d", tag, r), w_o, exp_row(r, base, konst));
      end
   endtask

   task automatic chk_done(input string tag);
      chk({tag, "_load_done"}, {119'h0, load_done}, 120'h1);
      chk({tag, "_loaded"}, {119'h0, loaded}, 120'h1);
      chk({tag, "_busy"}, {119'h0, busy}, 120'h0);
      @(posedge clk); @(negedge clk);
      chk({tag, "_load_done_low"}, {119'h0, load_done}, 120'h0);
      chk({tag, "_done_pulses"}, 120'(done_cnt - d0), 120'd1);
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 24'h0; addr = 8'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);

      // 1: reset state
      for (int a = 0; a < 8; a++) begin
         addr = 8'(a); #1;
         chk($sformatf("reset_w_addr%0d", a), w_o, 120'h0);
      end
      chk("reset_loaded", {119'h0, loaded}, 120'h0);
      chk("reset_in_ready", {119'h0, in_ready}, 120'h0);
      chk("reset_busy", {119'h0, busy}, 120'h0);
      chk("reset_load_done", {119'h0, load_done}, 120'h0);
      @(negedge clk);

      // 2: back-to-back load of 1..30
      d0 = done_cnt; a0 = accept_cnt;
      start_load();
      chk("t2_busy", {119'h0, busy}, 120'h1);
      chk("t2_in_ready", {119'h0, in_ready}, 120'h1);
      feed(0, 30, 24'h000001, 1'b0, 1'b0);
      chk_done("t2");
      chk("t2_accepts", 120'(accept_cnt - a0), 120'd30);
      addr = 8'd0; #1;
      chk("t2_row0_lit", w_o, 120'h000001_000002_000003_000004_000005);
      addr = 8'd5; #1;
      chk("t2_row5_lit", w_o, 120'h00001A_00001B_00001C_00001D_00001E);
      addr = 8'd6; #1;
      chk("t2_addr6", w_o, 120'h0);
      addr = 8'd255; #1;
      chk("t2_addr255", w_o, 120'h0);
      chk_rows("t2", 24'h000001, 1'b0);
      @(negedge clk);

      // in_valid while idle must not write anything
      in_valid = 1'b1; in_data = 24'hABCDEF;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      in_valid = 1'b0;
      chk_rows("idle_ignore", 24'h000001, 1'b0);
      chk("idle_loaded", {119'h0, loaded}, 120'h1);
      @(negedge clk);

      // 3: same load with stalls
      d0 = done_cnt; a0 = accept_cnt;
      start_load();
      chk("t3_loaded_cleared", {119'h0, loaded}, 120'h0);
      feed(0, 30, 24'h000001, 1'b0, 1'b1);
      // the last gap cycle already consumed the pulse cycle
      chk("t3_loaded", {119'h0, loaded}, 120'h1);
      chk("t3_busy", {119'h0, busy}, 120'h0);
      chk("t3_done_pulses", 120'(done_cnt - d0), 120'd1);
      chk("t3_accepts", 120'(accept_cnt - a0), 120'd30);
      chk_rows("t3", 24'h000001, 1'b0);
      @(negedge clk);

      // 4: load_start mid-load is ignored
      d0 = done_cnt; a0 = accept_cnt;
      start_load();
      feed(0, 12, 24'h000101, 1'b0, 1'b0);
      start_load();
      chk("t4_busy_after_restart", {119'h0, busy}, 120'h1);
      chk("t4_loaded_mid", {119'h0, loaded}, 120'h0);
      feed(12, 18, 24'h000101, 1'b0, 1'b0);
      chk_done("t4");
      chk("t4_accepts", 120'(accept_cnt - a0), 120'd30);
      chk_rows("t4", 24'h000101, 1'b0);
      @(negedge clk);

      // 5: reset after 7 elements discards everything
      start_load();
      feed(0, 7, 24'h000201, 1'b0, 1'b0);
      rst = 1'b1; #1;
      chk("t5_busy", {119'h0, busy}, 120'h0);
      chk("t5_loaded", {119'h0, loaded}, 120'h0);
      chk("t5_in_ready", {119'h0, in_ready}, 120'h0);
      for (int r = 0; r < 6; r++) begin
         addr = 8'(r); #1;
         chk($sformatf("t5_rst_row%0d", r), w_o, 120'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      d0 = done_cnt;
      start_load();
      feed(0, 30, 24'h000301, 1'b0, 1'b0);
      chk_done("t5");
      chk_rows("t5", 24'h000301, 1'b0);
      @(negedge clk);

      // 6: all-ones load, then partial reload with 0x800000
      d0 = done_cnt;
      start_load();
      feed(0, 30, 24'hFFFFFF, 1'b1, 1'b0);
      chk_done("t6a");
      chk_rows("t6a", 24'hFFFFFF, 1'b1);
      @(negedge clk);
      d0 = done_cnt;
      start_load();
      feed(0, 2, 24'h800000, 1'b1, 1'b0);
      addr = 8'd0; #1;
      chk("t6_partial_row0", w_o, 120'h800000_800000_FFFFFF_FFFFFF_FFFFFF);
      chk("t6_loaded_mid", {119'h0, loaded}, 120'h0);
      @(negedge clk);
      feed(2, 27, 24'h800000, 1'b1, 1'b0);
      chk("t6_loaded_before_last", {119'h0, loaded}, 120'h0);
      addr = 8'd5; #1;
      chk("t6_partial_row5", w_o, 120'h800000_800000_800000_800000_FFFFFF);
      @(negedge clk);
      feed(29, 1, 24'h800000, 1'b1, 1'b0);
      chk_done("t6b");
      chk_rows("t6b", 24'h800000, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
